// File: rtl/bsg_cgol_pkg.sv
// bsg_cgol_pkg: serializer state type and sizing helpers shared by the CGoL output path
package bsg_cgol_pkg;

    typedef enum logic {eIDLE, eSEND} serializer_state_e;

    // clog2 that never returns 0, so a one-state counter still gets a bit
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // words needed to carry `cells` bits in `width`-bit beats, at least one
    function automatic int num_words(input int cells, input int width);
        return (cells <= width) ? 1 : (cells + width - 1) / width;
    endfunction

endpackage

// File: rtl/bsg_cgol_output_serializer_if.sv
// bsg_cgol_output_serializer_if: valid/ready word stream toward the host link
// Signals: data_o (word), v_o (valid), last_o (final beat of board), ready_i (sink ready)
interface bsg_cgol_output_serializer_if #(parameter int data_width_p = 16);

    logic [data_width_p-1:0] data_o;
    logic                    v_o;
    logic                    last_o;
    logic                    ready_i;

    modport master (output data_o, v_o, last_o, input ready_i);
    modport slave  (input data_o, v_o, last_o, output ready_i);

endinterface

// File: rtl/bsg_cgol_popcount.sv
// bsg_cgol_popcount: combinational live-cell count as a recursive balanced adder tree
// Ports: data_i (width_p bits), count_o (number of ones)
module bsg_cgol_popcount
    import bsg_cgol_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic [width_p-1:0]                  data_i,
    output logic [safe_clog2(width_p+1)-1:0]    count_o
);

    if (width_p == 1) begin : g_leaf
        assign count_o = data_i;
    end else begin : g_node
        localparam int lo_w_lp = width_p / 2;
        localparam int hi_w_lp = width_p - lo_w_lp;
        localparam int cnt_w_lp = safe_clog2(width_p + 1);
        logic [safe_clog2(lo_w_lp+1)-1:0] lo;
        logic [safe_clog2(hi_w_lp+1)-1:0] hi;
        bsg_cgol_popcount #(.width_p(lo_w_lp)) u_lo (.data_i(data_i[lo_w_lp-1:0]), .count_o(lo));
        bsg_cgol_popcount #(.width_p(hi_w_lp)) u_hi (.data_i(data_i[width_p-1:lo_w_lp]), .count_o(hi));
        assign count_o = cnt_w_lp'(lo) + cnt_w_lp'(hi);
    end

endmodule

// File: rtl/bsg_cgol_output_serializer.sv
// bsg_cgol_output_serializer: accepts one CGoL board snapshot and streams it out as data_width_p-bit words
// Ports: clk_i, reset_i (sync, active-high); data_i/v_i/yumi_o snapshot handshake from the controller;
//        link (master) carries data_o/v_o/last_o/ready_i toward the host.
// Option: BSG_CGOL_SERIALIZER_HEADER_EN prepends a popcount header beat to every board.
module bsg_cgol_output_serializer
    import bsg_cgol_pkg::*;
#(
    parameter int board_width_p  = 8,
    parameter int board_height_p = 8,
    parameter int data_width_p   = 16
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [board_width_p*board_height_p-1:0]   data_i,
    input  logic                                      v_i,
    output logic                                      yumi_o,
    bsg_cgol_output_serializer_if.master              link
);

    localparam int num_cells_lp = board_width_p * board_height_p;
    localparam int num_words_lp = num_words(num_cells_lp, data_width_p);
`ifdef BSG_CGOL_SERIALIZER_HEADER_EN
    localparam int hdr_beats_lp = 1;
`else
    localparam int hdr_beats_lp = 0;
`endif
    localparam int beats_lp   = num_words_lp + hdr_beats_lp;
    localparam int shift_w_lp = beats_lp * data_width_p;
    localparam int cnt_w_lp   = safe_clog2(beats_lp + 1);

    serializer_state_e       state_r, state_n;
    logic [cnt_w_lp-1:0]     cnt_r;
    logic [shift_w_lp-1:0]   shift_r, load;
    logic                    last_beat, hs;

`ifdef BSG_CGOL_SERIALIZER_HEADER_EN
    localparam int pop_w_lp = safe_clog2(num_cells_lp + 1);
    logic [pop_w_lp-1:0] pop;

    if (data_width_p < pop_w_lp) begin : g_hdr_width_check
        $error("data_width_p too narrow to carry the popcount header");
    end

    bsg_cgol_popcount #(.width_p(num_cells_lp)) u_popcount (.data_i(data_i), .count_o(pop));

    // header sits in the lowest word so it leaves first
    assign load = {(num_words_lp*data_width_p)'(data_i), data_width_p'(pop)};
`else
    assign load = shift_w_lp'(data_i);
`endif

    always_comb begin
        last_beat   = cnt_r == cnt_w_lp'(beats_lp - 1);
        link.v_o    = state_r == eSEND;
        link.last_o = link.v_o & last_beat;
        link.data_o = shift_r[data_width_p-1:0];
        hs          = link.v_o & link.ready_i;
        // upstream valid is registered, so consuming it combinationally is safe
        yumi_o      = (state_r == eIDLE) & v_i;
        state_n     = (state_r == eIDLE) ? (v_i ? eSEND : eIDLE)
                                         : ((hs & last_beat) ? eIDLE : eSEND);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            cnt_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_n;
            if (yumi_o) begin
                shift_r <= load;
                cnt_r   <= '0;
            end else if (hs) begin
                shift_r <= shift_r >> data_width_p;
                cnt_r   <= last_beat ? '0 : cnt_r + cnt_w_lp'(1);
            end
        end
    end

endmodule

// File: tb/tb_bsg_cgol_output_serializer.sv
// tb_bsg_cgol_output_serializer: randomized + directed bench with a queue-based reference model
module tb_bsg_cgol_output_serializer;

`ifdef BSG_CGOL_SERIALIZER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = 4 + HDR;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [63:0] data_i = '0;
    logic        v_i = 1'b0;
    logic        yumi_o;
    logic [24:0] data2_i = '0;
    logic        v2_i = 1'b0;
    logic        yumi2_o;

    int tests = 0;
    int fails = 0;
    int yumi_cnt = 0;
    bit armed = 1'b0;

    logic [16:0] q[$];
    logic [16:0] log_q[$];
    logic [16:0] exp_a[$];
    logic [8:0]  log2[$];
    logic [8:0]  exp_p[$];

    always #5 clk_i = ~clk_i;

    bsg_cgol_output_serializer_if #(.data_width_p(16)) link ();
    bsg_cgol_output_serializer_if #(.data_width_p(8))  link2 ();

    bsg_cgol_output_serializer #(.board_width_p(8), .board_height_p(8), .data_width_p(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .yumi_o(yumi_o), .link(link)
    );

    bsg_cgol_output_serializer #(.board_width_p(5), .board_height_p(5), .data_width_p(8)) dut_pad (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data2_i), .v_i(v2_i), .yumi_o(yumi2_o), .link(link2)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // expected beats of one board: optional popcount header, then 16-bit slices LSB first
    function automatic void load_board(input logic [63:0] b);
        if (HDR != 0) q.push_back({1'b0, 16'($countones(b))});
        for (int k = 0; k < 4; k++) q.push_back({k == 3, b[k*16 +: 16]});
    endfunction

    always @(negedge clk_i) begin
        if (armed) begin
            if (yumi_o === 1'b1) yumi_cnt++;
            if (q.size() > 0) begin
                chk("v_o busy", 32'(link.v_o), 32'd1);
                chk("yumi_o busy", 32'(yumi_o), 32'd0);
                chk("data_o", 32'(link.data_o), 32'(q[0][15:0]));
                chk("last_o", 32'(link.last_o), 32'(q[0][16]));
                if (link.ready_i) log_q.push_back({link.last_o, link.data_o});
            end else begin
                chk("v_o idle", 32'(link.v_o), 32'd0);
                chk("last_o idle", 32'(link.last_o), 32'd0);
                chk("yumi_o idle", 32'(yumi_o), 32'(v_i));
            end
        end
        if (reset_i) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (q.size() > 0) begin
                if (link.ready_i) void'(q.pop_front());
            end else if (v_i) begin
                load_board(data_i);
            end
        end
    end

    always @(negedge clk_i)
        if (link2.v_o === 1'b1 && link2.ready_i) log2.push_back({link2.last_o, link2.data_o});

    task automatic wait_log(input int n);
        for (int i = 0; i < 60 && log_q.size() < n; i++) step();
        if (log_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL wait_log: got %0d beats, required %0d", log_q.size(), n);
        end
    endtask

    task automatic cmp_log(input string n);
        chk({n, " beats"}, 32'(log_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_q.size(); i++) chk(n, 32'(log_q[i]), 32'(exp_a[i]));
    endtask

    initial begin
        int y0;
        if (HDR != 0) exp_a.push_back(17'h00020);
        exp_a.push_back(17'h0CDEF);
        exp_a.push_back(17'h089AB);
        exp_a.push_back(17'h04567);
        exp_a.push_back(17'h10123);
        if (HDR != 0) exp_p.push_back(9'h019);
        exp_p.push_back(9'h0FF);
        exp_p.push_back(9'h0FF);
        exp_p.push_back(9'h0FF);
        exp_p.push_back(9'h101);
        link.ready_i = 1'b1;
        link2.ready_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;
        #1;
        chk("reset v_o", 32'(link.v_o), 32'd0);
        chk("reset last_o", 32'(link.last_o), 32'd0);
        chk("reset data_o", 32'(link.data_o), 32'd0);
        chk("reset yumi_o", 32'(yumi_o), 32'd0);

        log_q.delete();
        data_i = 64'h0123_4567_89AB_CDEF;
        v_i = 1'b1;
        #1;
        chk("basic yumi_o", 32'(yumi_o), 32'd1);
        step();
        v_i = 1'b0;
        wait_log(NB);
        cmp_log("basic drain");

        log_q.delete();
        v_i = 1'b1;
        step();
        v_i = 1'b0;
        for (int i = 0; i < 20 && !(link.v_o && link.data_o == 16'h89AB); i++) step();
        link.ready_i = 1'b0;
        repeat (3) step();
        chk("bp hold data", 32'(link.data_o), 32'h89AB);
        chk("bp hold v_o", 32'(link.v_o), 32'd1);
        chk("bp hold last", 32'(link.last_o), 32'd0);
        link.ready_i = 1'b1;
        step();
        chk("bp advance", 32'(link.data_o), 32'h4567);
        wait_log(NB);
        cmp_log("backpressure");

        log_q.delete();
        y0 = yumi_cnt;
        v_i = 1'b1;
        wait_log(2 * NB);
        v_i = 1'b0;
        step();
        chk("reaccept yumi count", 32'(yumi_cnt - y0), 32'd2);
        chk("reaccept beats", 32'(log_q.size()), 32'(2 * NB));
        for (int i = 0; i < 2 * NB && i < log_q.size(); i++) chk("reaccept word", 32'(log_q[i]), 32'(exp_a[i % NB]));

        log_q.delete();
        v_i = 1'b1;
        step();
        v_i = 1'b0;
        wait_log(2);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("reset mid v_o", 32'(link.v_o), 32'd0);
        log_q.delete();
        data_i = 64'hFFFF_0000_FFFF_0000;
        v_i = 1'b1;
        step();
        v_i = 1'b0;
        wait_log(NB);
        if (HDR != 0) chk("board B header", 32'(log_q[0]), 32'h00020);
        chk("board B first word", 32'(log_q[HDR]), 32'h00000);
        chk("board B last word", 32'(log_q[NB-1]), 32'h1FFFF);

        log2.delete();
        data2_i = 25'h1FF_FFFF;
        v2_i = 1'b1;
        #1;
        chk("pad yumi_o", 32'(yumi2_o), 32'd1);
        step();
        v2_i = 1'b0;
        for (int i = 0; i < 20 && log2.size() < exp_p.size(); i++) step();
        chk("pad beats", 32'(log2.size()), 32'(exp_p.size()));
        for (int i = 0; i < exp_p.size() && i < log2.size(); i++) chk("pad word", 32'(log2[i]), 32'(exp_p[i]));

        for (int i = 0; i < 600; i++) begin
            v_i = 1'($urandom_range(0, 1));
            data_i = {$urandom, $urandom};
            link.ready_i = ($urandom_range(0, 3) != 0);
            reset_i = ($urandom_range(0, 59) == 0);
            step();
        end
        reset_i = 1'b0;
        v_i = 1'b0;
        link.ready_i = 1'b1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_cgol_output_serializer.md
Name: bsg_cgol_output_serializer

Overview:
- Downstream stage of the CGoL controller/cell array: accepts the final board snapshot once the game completes.
- Consumes the snapshot with a valid/yumi handshake; the board's `v_o` drives our `v_i`, our `yumi_o` drives its `yumi_i`.
- Streams the board out as fixed-width words over a valid/ready channel toward the host link.
- Only one snapshot is ever in flight: a new board is accepted only after the previous one has fully drained.

Parameters:
- board_width_p, 8, cells per row.
- board_height_p, 8, rows; num_cells_lp = board_width_p*board_height_p.
- data_width_p, 16, output word width; num_words_lp = ceil(num_cells_lp/data_width_p), minimum 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- data_i  in  num_cells_lp  board snapshot; cell index r*board_width_p+c at bit r*board_width_p+c.
- v_i  in  1  snapshot valid (from controller `v_o`).
- yumi_o  out  1  snapshot consumed this cycle (to controller `yumi_i`).
- data_o  out  data_width_p  serialized word.
- v_o  out  1  data_o valid.
- ready_i  in  1  downstream ready.
- last_o  out  1  current beat is the final beat of the board.

Behaviour:
- Reset: synchronous active-high on clk_i. State→eIDLE, beat counter→0, shift register→0. Outputs during/after reset: yumi_o=0 (unless v_i in eIDLE after reset deasserts), v_o=0, last_o=0, data_o=0.
- FSM states: eIDLE, eSEND.
- eIDLE:
  - yumi_o = v_i (combinational; legal because upstream valid is registered).
  - On v_i: data_i is zero-extended to num_words_lp*data_width_p and loaded into the shift register; counter←0; next state eSEND.
  - v_o=0 in this state.
- eSEND:
  - v_o=1; data_o = shift_r[data_width_p-1:0]; yumi_o=0 regardless of v_i.
  - Handshake is v_o & ready_i. On handshake: shift_r shifts right by data_width_p (zero fill) and counter increments.
  - If counter==num_words_lp-1 at handshake: next state eIDLE, counter←0.
  - Without ready_i: data_o, v_o, and last_o hold stable.
- last_o = v_o & (counter==num_words_lp-1).
- Word order: word k carries cells [k*data_width_p +: data_width_p], so cell 0 is the LSB of the first word. Unused high bits of the final word are 0.
- Latency and throughput:
  - First beat appears the cycle after yumi_o.
  - One word per cycle while ready_i=1.
  - A minimum of one idle cycle separates the last beat of one board from the yumi_o of the next.
- num_words_lp==1: single beat with last_o=1.
- Reset mid-transfer: the remaining words are discarded. v_o drops the cycle after reset_i is sampled. The next accepted board starts from word 0.
- Counter width is `BSG_SAFE_CLOG2(num_words_lp+1)`. It never wraps past num_words_lp-1.

Optional Feature:
- Macro: BSG_CGOL_SERIALIZER_HEADER_EN.
- Defined:
  - A header beat precedes the data words. The header is the live-cell popcount of data_i, captured at yumi_o and zero-extended to data_width_p.
  - Total beats = num_words_lp+1; last_o is asserted on the final data word only.
  - An elaboration-time assertion requires data_width_p >= `BSG_SAFE_CLOG2(num_cells_lp+1)`.
- Undefined: no header and no popcount logic; behaviour is exactly as described above.

Decomposition:
- Shared package bsg_cgol_pkg holds:
  - the serializer state enum (eIDLE, eSEND);
  - a function computing num_words_lp from cell count and word width.
- Sub-module bsg_cgol_popcount (purely combinational adder tree, parameter width_p) is instantiated only under BSG_CGOL_SERIALIZER_HEADER_EN.
- The beat counter and shift register stay inline.

Test Plan:
- Basic drain (8x8, width 16, ready_i=1): data_i=64'h0123_4567_89AB_CDEF, v_i=1.
  - yumi_o=1 for one cycle.
  - data_o sequence 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123 on consecutive cycles; last_o only on 16'h0123.
- Backpressure: same board, ready_i=0 for 3 cycles while 16'h89AB is presented.
  - data_o holds 16'h89AB with v_o=1 and last_o=0; it advances to 16'h4567 the cycle after ready_i returns to 1.
- No re-accept during send: v_i held at 1 throughout the transfer.
  - yumi_o=0 for all of eSEND.
  - yumi_o=1 exactly one cycle after the last beat; the second board's first word follows the next cycle.
- Padding (5x5, width 8): data_i=25'h1FFFFFF.
  - 4 beats: 8'hFF, 8'hFF, 8'hFF, 8'h01; last_o on 8'h01.
- Reset mid-transfer: after 2 beats of board A, pulse reset_i for 1 cycle.
  - v_o=0 the next cycle.
  - Board B (64'hFFFF_0000_FFFF_0000) then emits 16'h0000 as its first word, with counter restarted.
- Header (macro defined, 8x8, width 16): board 64'h0123_4567_89AB_CDEF.
  - First beat 16'h0020 (popcount 32), then the four data words; 5 beats total, last_o on beat 5.
